// File: rtl/regfile_operand_fetch_pkg.sv
// Shared definitions for the register-file operand-fetch stage.
// The state encoding and the hard-wired zero register index live here.
package regfile_operand_fetch_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } of_state_t;

  localparam int ZERO_REG_IDX = 0;

  function automatic logic is_zero_reg(input logic [31:0] addr, input int zero_en);
    return (zero_en != 0) && (addr == 32'(ZERO_REG_IDX));
  endfunction

endpackage

// File: rtl/regfile_operand_fetch_bypass_mux.sv
// One read port of the operand-fetch stage: registered read-during-write forwarding
// (built only with `OPERAND_BYPASS_EN) followed by zero-register forcing.
module regfile_bypass_mux
  import regfile_operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [ADDR_WIDTH-1:0] i_rs_held,
  input  logic                  i_wb_we,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic [DATA_WIDTH-1:0] o_operand
);

  logic [DATA_WIDTH-1:0] w_fwd;

`ifdef OPERAND_BYPASS_EN
  logic                  r_hit;
  logic [DATA_WIDTH-1:0] r_byp_data;
  logic                  w_hit_next;

  // The RAM returns old data when read and written in the same cycle.
  assign w_hit_next = i_wb_we && (i_wb_addr == i_rd_addr) &&
                      !is_zero_reg(32'(i_rd_addr), ZERO_REG);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= w_hit_next;
    end
  end

  always_ff @(posedge clk) begin
    r_byp_data <= i_wb_data;
  end

  assign w_fwd = r_hit ? r_byp_data : i_ram_data;
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{clk, reset_n, i_rd_addr, i_wb_we, i_wb_addr, i_wb_data};
  assign w_fwd           = i_ram_data;
`endif

  assign o_operand = is_zero_reg(32'(i_rs_held), ZERO_REG) ? '0 : w_fwd;

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage between decode and a 2R/1W register-file RAM with registered reads.
// Optional read-during-write forwarding is enabled by defining OPERAND_BYPASS_EN.
module regfile_operand_fetch
  import regfile_operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int PAYLOAD_WIDTH = 16,
  parameter int ZERO_REG      = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_rs_a,
  input  logic [ADDR_WIDTH-1:0]    in_rs_b,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_op_a,
  output logic [DATA_WIDTH-1:0]    out_op_b,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  input  logic                     wb_we,
  input  logic [ADDR_WIDTH-1:0]    wb_addr,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic [ADDR_WIDTH-1:0]    ram_addr_r_a,
  output logic [ADDR_WIDTH-1:0]    ram_addr_r_b,
  output logic [ADDR_WIDTH-1:0]    ram_addr_w,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  output logic                     ram_we,
  input  logic [DATA_WIDTH-1:0]    ram_data_a,
  input  logic [DATA_WIDTH-1:0]    ram_data_b
);

  of_state_t                r_state;
  of_state_t                w_state_next;
  logic [ADDR_WIDTH-1:0]    r_rs_a;
  logic [ADDR_WIDTH-1:0]    r_rs_b;
  logic [PAYLOAD_WIDTH-1:0] r_payload;
  logic                     w_accept;
  logic                     w_in_ready;

  assign w_in_ready = (r_state == ST_EMPTY) || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
      ST_FULL:  if (out_ready && !in_valid) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  // Instruction registers: the held source numbers keep the RAM re-reading while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rs_a    <= '0;
      r_rs_b    <= '0;
      r_payload <= '0;
    end else if (w_accept) begin
      r_rs_a    <= in_rs_a;
      r_rs_b    <= in_rs_b;
      r_payload <= in_payload;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = (r_state == ST_FULL);
  assign out_payload  = r_payload;
  assign ram_addr_r_a = w_accept ? in_rs_a : r_rs_a;
  assign ram_addr_r_b = w_accept ? in_rs_b : r_rs_b;

  // Writeback passes straight through; register 0 writes and writes during reset are dropped.
  assign ram_addr_w  = wb_addr;
  assign ram_data_in = wb_data;
  assign ram_we      = reset_n && wb_we && !is_zero_reg(32'(wb_addr), ZERO_REG);

  regfile_bypass_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_port_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_rd_addr  (ram_addr_r_a),
    .i_rs_held  (r_rs_a),
    .i_wb_we    (wb_we),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .i_ram_data (ram_data_a),
    .o_operand  (out_op_a)
  );

  regfile_bypass_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_port_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_rd_addr  (ram_addr_r_b),
    .i_rs_held  (r_rs_b),
    .i_wb_we    (wb_we),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .i_ram_data (ram_data_b),
    .o_operand  (out_op_b)
  );

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch with a behavioural read-old-data register-file RAM.
module tb_regfile_operand_fetch;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int PW = 16;

`ifdef OPERAND_BYPASS_EN
  localparam logic [DW-1:0] T2_OP_A = 32'h0000_00AB;
  localparam logic [DW-1:0] S3_OP_B = 32'h0000_0077;
`else
  localparam logic [DW-1:0] T2_OP_A = 32'h0000_0105;
  localparam logic [DW-1:0] S3_OP_B = 32'h0000_0109;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, out_valid, out_ready, wb_we, ram_we;
  logic [AW-1:0] in_rs_a, in_rs_b, wb_addr, ram_addr_r_a, ram_addr_r_b, ram_addr_w;
  logic [PW-1:0] in_payload, out_payload;
  logic [DW-1:0] out_op_a, out_op_b, wb_data, ram_data_in, ram_data_a, ram_data_b;

  always #5 clk = ~clk;

  regfile_operand_fetch #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PAYLOAD_WIDTH(PW), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rs_a(in_rs_a), .in_rs_b(in_rs_b),
    .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_payload(out_payload),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ram_addr_r_a(ram_addr_r_a), .ram_addr_r_b(ram_addr_r_b), .ram_addr_w(ram_addr_w),
    .ram_data_in(ram_data_in), .ram_we(ram_we),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b)
  );

  // Register file RAM: registered reads return the pre-write contents.
  // Register 0 starts non-zero so only the stage's zero forcing can produce 0.
  logic [DW-1:0] mem [16];
  logic          mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 32'hDEAD : 32'h100 + 32'(i);
    end else if (ram_we) begin
      mem[ram_addr_w] <= ram_data_in;
    end
    ram_data_a <= mem[ram_addr_r_a];
    ram_data_b <= mem[ram_addr_r_b];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [PW-1:0] pl, input logic ordy, input logic we,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    in_valid = iv; in_rs_a = ra; in_rs_b = rb; in_payload = pl;
    out_ready = ordy; wb_we = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          iv;
    logic [AW-1:0] ra, rb;
    logic [PW-1:0] pl;
    logic          ordy, we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          e_irdy, e_ov, e_rwe;
    logic [DW-1:0] e_a, e_b;
    logic [PW-1:0] e_pl;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                              input logic [PW-1:0] pl, input logic ordy, input logic we,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic e_irdy, input logic e_ov, input logic e_rwe,
                              input logic [DW-1:0] e_a, input logic [DW-1:0] e_b,
                              input logic [PW-1:0] e_pl);
    vec_t v;
    v.iv = iv; v.ra = ra; v.rb = rb; v.pl = pl; v.ordy = ordy; v.we = we; v.wa = wa; v.wd = wd;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_rwe = e_rwe; v.e_a = e_a; v.e_b = e_b; v.e_pl = e_pl;
    return v;
  endfunction

  vec_t vt [17];
  int   hs;

  initial begin
    // One row per cycle: inputs for that cycle, outputs expected during it.
    vt[0]  = mk(0, 4'd0, 4'd0,  16'h0,  1, 1, 4'd3, 32'h11, 1, 0, 1, 32'h0,   32'h0,   16'h0);
    vt[1]  = mk(0, 4'd0, 4'd0,  16'h0,  1, 0, 4'd0, 32'h0,  1, 0, 0, 32'h0,   32'h0,   16'h0);
    vt[2]  = mk(1, 4'd3, 4'd0,  16'h1,  1, 0, 4'd0, 32'h0,  1, 0, 0, 32'h0,   32'h0,   16'h0);
    vt[3]  = mk(0, 4'd0, 4'd0,  16'h0,  1, 0, 4'd0, 32'h0,  1, 1, 0, 32'h11,  32'h0,   16'h1);
    vt[4]  = mk(0, 4'd0, 4'd0,  16'h0,  1, 1, 4'd0, 32'hFF, 1, 0, 0, 32'h0,   32'h0,   16'h0);
    vt[5]  = mk(1, 4'd0, 4'd0,  16'h2,  1, 0, 4'd0, 32'h0,  1, 0, 0, 32'h0,   32'h0,   16'h0);
    vt[6]  = mk(0, 4'd0, 4'd0,  16'h0,  1, 0, 4'd0, 32'h0,  1, 1, 0, 32'h0,   32'h0,   16'h2);
    vt[7]  = mk(1, 4'd1, 4'd15, 16'h11, 1, 0, 4'd0, 32'h0,  1, 0, 0, 32'h0,   32'h0,   16'h0);
    vt[8]  = mk(1, 4'd2, 4'd14, 16'h12, 1, 0, 4'd0, 32'h0,  1, 1, 0, 32'h101, 32'h10F, 16'h11);
    vt[9]  = mk(1, 4'd3, 4'd13, 16'h13, 1, 0, 4'd0, 32'h0,  1, 1, 0, 32'h102, 32'h10E, 16'h12);
    vt[10] = mk(1, 4'd4, 4'd12, 16'h14, 1, 0, 4'd0, 32'h0,  1, 1, 0, 32'h11,  32'h10D, 16'h13);
    vt[11] = mk(1, 4'd5, 4'd11, 16'h15, 1, 0, 4'd0, 32'h0,  1, 1, 0, 32'h104, 32'h10C, 16'h14);
    vt[12] = mk(1, 4'd6, 4'd10, 16'h16, 1, 0, 4'd0, 32'h0,  1, 1, 0, 32'h105, 32'h10B, 16'h15);
    vt[13] = mk(1, 4'd7, 4'd9,  16'h17, 1, 0, 4'd0, 32'h0,  1, 1, 0, 32'h106, 32'h10A, 16'h16);
    vt[14] = mk(1, 4'd8, 4'd8,  16'h18, 1, 0, 4'd0, 32'h0,  1, 1, 0, 32'h107, 32'h109, 16'h17);
    vt[15] = mk(0, 4'd0, 4'd0,  16'h0,  1, 0, 4'd0, 32'h0,  1, 1, 0, 32'h108, 32'h108, 16'h18);
    vt[16] = mk(0, 4'd0, 4'd0,  16'h0,  1, 0, 4'd0, 32'h0,  1, 0, 0, 32'h0,   32'h0,   16'h0);

    // Reset: a writeback offered during reset must not reach the RAM.
    reset_n  = 1'b0;
    mem_init = 1'b1;
    drive(0, 4'd0, 4'd0, 16'h0, 0, 1, 4'd3, 32'h55);
    @(negedge clk);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset ram_we", ram_we, 1'b0);
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset payload", out_payload, 16'h0);
    next_cycle();
    reset_n  = 1'b1;
    mem_init = 1'b0;

    // Tests 1, 4 and 5 as a cycle table.
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].iv, vt[i].ra, vt[i].rb, vt[i].pl, vt[i].ordy, vt[i].we, vt[i].wa, vt[i].wd);
      @(negedge clk);
      chk($sformatf("row%0d in_ready", i), in_ready, vt[i].e_irdy);
      chk($sformatf("row%0d out_valid", i), out_valid, vt[i].e_ov);
      chk($sformatf("row%0d ram_we", i), ram_we, vt[i].e_rwe);
      if (vt[i].e_ov) begin
        chk($sformatf("row%0d op_a", i), out_op_a, vt[i].e_a);
        chk($sformatf("row%0d op_b", i), out_op_b, vt[i].e_b);
        chk($sformatf("row%0d payload", i), out_payload, vt[i].e_pl);
      end
      next_cycle();
    end

    // Test 2: issue rs_a=5 in the same cycle R5 is written.
    drive(1, 4'd5, 4'd6, 16'h55, 1, 1, 4'd5, 32'hAB);
    @(negedge clk);
    chk("t2 rd addr a", ram_addr_r_a, 4'd5);
    chk("t2 ram_addr_w", ram_addr_w, 4'd5);
    next_cycle();
    drive(0, 4'd0, 4'd0, 16'h0, 0, 0, 4'd0, 32'h0);
    @(negedge clk);
    chk("t2 out_valid", out_valid, 1'b1);
    chk("t2 op_a write cycle", out_op_a, T2_OP_A);
    chk("t2 op_b", out_op_b, 32'h106);
    next_cycle();
    drive(0, 4'd0, 4'd0, 16'h0, 1, 0, 4'd0, 32'h0);
    @(negedge clk);
    chk("t2 op_a later", out_op_a, 32'hAB);
    next_cycle();

    // Test 3: stall four cycles with a newer instruction waiting, write R9 mid-stall.
    hs = 0;
    drive(1, 4'd7, 4'd9, 16'h077A, 1, 0, 4'd0, 32'h0);
    next_cycle();
    for (int s = 1; s <= 4; s++) begin
      drive(1, 4'd10, 4'd11, 16'h0BBB, 0, (s == 2), 4'd9, 32'h77);
      @(negedge clk);
      hs += int'(out_valid && out_ready);
      chk($sformatf("t3 s%0d in_ready", s), in_ready, 1'b0);
      chk($sformatf("t3 s%0d out_valid", s), out_valid, 1'b1);
      chk($sformatf("t3 s%0d payload", s), out_payload, 16'h077A);
      chk($sformatf("t3 s%0d rd addr a", s), ram_addr_r_a, 4'd7);
      chk($sformatf("t3 s%0d op_a", s), out_op_a, 32'h107);
      chk($sformatf("t3 s%0d op_b", s), out_op_b,
          (s <= 2) ? 32'h109 : ((s == 3) ? S3_OP_B : 32'h77));
      next_cycle();
    end
    drive(1, 4'd10, 4'd11, 16'h0BBB, 1, 0, 4'd0, 32'h0);
    @(negedge clk);
    hs += int'(out_valid && out_ready);
    chk("t3 release in_ready", in_ready, 1'b1);
    chk("t3 release op_b", out_op_b, 32'h77);
    chk("t3 handshakes", hs, 1);
    next_cycle();
    drive(0, 4'd0, 4'd0, 16'h0, 0, 0, 4'd0, 32'h0);
    @(negedge clk);
    chk("t3 next payload", out_payload, 16'h0BBB);
    chk("t3 next op_a", out_op_a, 32'h10A);
    chk("t3 next op_b", out_op_b, 32'h10B);
    next_cycle();
    drive(0, 4'd0, 4'd0, 16'h0, 1, 0, 4'd0, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("t3 drained", out_valid, 1'b0);
    next_cycle();

    // Test 6: asynchronous reset while FULL.
    drive(1, 4'd1, 4'd2, 16'h0661, 0, 0, 4'd0, 32'h0);
    next_cycle();
    drive(0, 4'd0, 4'd0, 16'h0, 0, 1, 4'd4, 32'h99);
    @(negedge clk);
    chk("t6 full before reset", out_valid, 1'b1);
    chk("t6 ram_we before reset", ram_we, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6 async out_valid", out_valid, 1'b0);
    chk("t6 async ram_we", ram_we, 1'b0);
    next_cycle();
    reset_n = 1'b1;
    drive(0, 4'd0, 4'd0, 16'h0, 1, 0, 4'd0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("t6 idle%0d out_valid", c), out_valid, 1'b0);
      next_cycle();
    end
    drive(1, 4'd1, 4'd4, 16'h0662, 1, 0, 4'd0, 32'h0);
    next_cycle();
    drive(0, 4'd0, 4'd0, 16'h0, 1, 0, 4'd0, 32'h0);
    @(negedge clk);
    chk("t6 new out_valid", out_valid, 1'b1);
    chk("t6 new op_a", out_op_a, 32'h101);
    chk("t6 new op_b", out_op_b, 32'h104);
    chk("t6 new payload", out_payload, 16'h0662);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
